// File: rtl/conv2d_stream_axis.sv
// conv2d_stream_axis: depthwise K x K streaming convolution, valid mode, AXI-Stream in/out.
// One lane per channel holds line buffers, window, coefficients and the two-stage datapath;
// the top owns position counters, line-length checking, handshake and the valid/user/last pipe.

module conv2d_stream_axis_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int K          = 3,
  parameter int IMG_WIDTH  = 64,
  parameter int SHIFT      = 8,
  parameter int CH         = 0,
  parameter int AW         = 5,
  parameter int CLW        = 6
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_en,
  input  logic                         i_acc,
  input  logic [CLW-1:0]               i_col,
  input  logic signed [DATA_WIDTH-1:0] i_pix,
  input  logic                         i_coef_we,
  input  logic [AW-1:0]                i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] i_coef_data,
  output logic signed [DATA_WIDTH-1:0] o_res
);
  localparam int KK = K * K;
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  // accumulator plus one bit of headroom for the rounding constant
  localparam int SW = PW + $clog2(KK) + 1;
  localparam logic signed [SW-1:0] RND  = (SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [COEF_WIDTH-1:0] r_coef [KK];
  logic signed [DATA_WIDTH-1:0] r_lb   [K-1][IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] w_lb_rd[K-1];
  logic signed [DATA_WIDTH-1:0] r_win  [K*(K-1)];
  logic signed [DATA_WIDTH-1:0] w_win  [KK];
  logic signed [PW-1:0]         w_prod [KK];
  logic signed [PW-1:0]         r_prod [KK];
  logic signed [SW-1:0]         w_sum, w_rnd, w_shf;
  logic signed [DATA_WIDTH-1:0] w_sat, r_res;

  // coefficient RAM: this lane owns addresses CH*KK .. CH*KK+KK-1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < KK; i++) r_coef[i] <= '0;
    end else if (i_coef_we) begin
      for (int i = 0; i < KK; i++)
        if ({1'b0, i_coef_addr} == (AW+1)'(CH*KK + i)) r_coef[i] <= i_coef_data;
    end
  end

  // line buffer read at the current column; lb[0] is the previous line
  always_comb begin
    for (int j = 0; j < K-1; j++) w_lb_rd[j] = r_lb[j][i_col];
  end

  // line buffers cascade one line deeper on every accepted beat
  always_ff @(posedge clk) begin
    if (i_acc) begin
      r_lb[0][i_col] <= i_pix;
      for (int j = 1; j < K-1; j++) r_lb[j][i_col] <= w_lb_rd[j-1];
    end
  end

  // window including the incoming column; row 0 oldest line, column 0 oldest column
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++) w_win[r*K+c] = r_win[r*(K-1)+c];
    for (int r = 0; r < K-1; r++) w_win[r*K+K-1] = w_lb_rd[K-2-r];
    w_win[KK-1] = i_pix;
  end

  // keep the newest K-1 columns for the next beat
  always_ff @(posedge clk) begin
    if (i_acc)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++) r_win[r*(K-1)+c] <= w_win[r*K+c+1];
  end

  // products against the current coefficients
  always_comb begin
    for (int i = 0; i < KK; i++) w_prod[i] = w_win[i] * r_coef[i];
  end

  // stage 1: product registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < KK; i++) r_prod[i] <= '0;
    end else if (i_en) begin
      for (int i = 0; i < KK; i++) r_prod[i] <= w_prod[i];
    end
  end

  // adder tree, round-half-up, arithmetic shift and saturation
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++) w_sum = w_sum + SW'(r_prod[i]);
    w_rnd = w_sum + RND;
    w_shf = w_rnd >>> SHIFT;
    if (w_shf > MAXV)      w_sat = MAXV[DATA_WIDTH-1:0];
    else if (w_shf < MINV) w_sat = MINV[DATA_WIDTH-1:0];
    else                   w_sat = w_shf[DATA_WIDTH-1:0];
  end

  // stage 2: output data register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   r_res <= '0;
    else if (i_en) r_res <= w_sat;
  end

  assign o_res = r_res;
endmodule

module conv2d_stream_axis #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int K          = 3,
  parameter int IMG_WIDTH  = 64,
  parameter int SHIFT      = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tuser,
  input  logic                             s_axis_tlast,
  output logic [NUM_CH*DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tlast,
  input  logic                             coef_we,
  input  logic [$clog2(NUM_CH*K*K)-1:0]    coef_addr,
  input  logic [COEF_WIDTH-1:0]            coef_data,
  output logic                             err_line_len
);
  localparam int CLW    = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(K+1);   // row saturates at K, enough to tell K-1 apart
  localparam int AW     = $clog2(NUM_CH*K*K);
  localparam int STAGES = 2;

  logic                 r_run, r_err;
  logic [CLW-1:0]       r_col, w_pcol;
  logic [RW-1:0]        r_row, w_prow;
  logic                 w_en, w_acc, w_eol, w_win_ok;
  logic [STAGES:1]      r_vld_pipe, r_usr_pipe, r_lst_pipe;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_res;

  assign s_axis_tready = r_run & (m_axis_tready | ~m_axis_tvalid);
  assign w_en     = s_axis_tready;
  assign w_acc    = s_axis_tvalid & s_axis_tready;
  assign w_pcol   = s_axis_tuser ? '0 : r_col;
  assign w_prow   = s_axis_tuser ? '0 : r_row;
  assign w_eol    = (w_pcol == CLW'(IMG_WIDTH-1));
  assign w_win_ok = (w_prow >= RW'(K-1)) && (w_pcol >= CLW'(K-1));

  // ready is held low until the first clock after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  // position counters; tlast or the last column both start a new line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (s_axis_tlast || w_eol) begin
        r_col <= '0;
        r_row <= (w_prow == RW'(K)) ? w_prow : w_prow + 1'b1;
      end else begin
        r_col <= w_pcol + 1'b1;
        r_row <= w_prow;
      end
    end
  end

  // sticky flag: tlast and the last column must coincide
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    r_err <= 1'b0;
    else if (w_acc && (s_axis_tlast != w_eol)) r_err <= 1'b1;
  end

  // valid/user/last travel alongside the lane datapath; border beats become bubbles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_pipe <= '0;
      r_usr_pipe <= '0;
      r_lst_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc & w_win_ok};
      r_usr_pipe <= {r_usr_pipe[STAGES-1:1],
                     w_acc & w_win_ok & (w_prow == RW'(K-1)) & (w_pcol == CLW'(K-1))};
      r_lst_pipe <= {r_lst_pipe[STAGES-1:1], w_acc & w_win_ok & w_eol};
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    conv2d_stream_axis_lane #(
      .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .K(K), .IMG_WIDTH(IMG_WIDTH),
      .SHIFT(SHIFT), .CH(ch), .AW(AW), .CLW(CLW)
    ) u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .i_en       (w_en),
      .i_acc      (w_acc),
      .i_col      (w_pcol),
      .i_pix      (s_axis_tdata[ch*DATA_WIDTH +: DATA_WIDTH]),
      .i_coef_we  (coef_we),
      .i_coef_addr(coef_addr),
      .i_coef_data(coef_data),
      .o_res      (w_res[ch])
    );
  end

  assign m_axis_tdata  = w_res;
  assign m_axis_tvalid = r_vld_pipe[STAGES];
  assign m_axis_tuser  = r_usr_pipe[STAGES];
  assign m_axis_tlast  = r_lst_pipe[STAGES];
  assign err_line_len  = r_err;
endmodule
